// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Holds state encodings, select codes and the rotating pick function.
package mux_rr_arbiter_pkg;

    localparam int REQ_NUM = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // First requester at or after ptr, scanning upward mod 4.
    // The loop runs from the farthest offset down so the nearest one wins.
    function automatic pick_t rr_pick(
        input logic [REQ_NUM-1:0] req,
        input logic [1:0]         ptr
    );
        pick_t      r;
        logic [1:0] i;
        r = '0;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            i = ptr + 2'(k);
            if (req[i]) begin
                r.found = 1'b1;
                r.idx   = i;
            end
        end
        return r;
    endfunction

    function automatic logic [REQ_NUM-1:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// Plain n-bit 4:1 multiplexer steered by a 2-bit select.
// Ports: A..D data words, S select, Y selected word.
import mux_rr_arbiter_pkg::*;

module Mux_4x1_nbit #(
    parameter int n = 8
) (
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic [n-1:0] C,
    input  logic [n-1:0] D,
    input  logic [1:0]   S,
    output logic [n-1:0] Y
);

    always_comb begin
        Y = A;
        unique case (S)
            SEL_A: Y = A;
            SEL_B: Y = B;
            SEL_C: Y = C;
            SEL_D: Y = D;
        endcase
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 mux, with a
// per-grant burst limit and a valid/ready handshake toward the consumer.
// Ports: clk, rst (async high), Req[3:0], A..D data, Ready in;
//        Gnt one-hot, S select, Y muxed word, Valid out.
import mux_rr_arbiter_pkg::*;

module mux_rr_arbiter #(
    parameter int n         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REQ_NUM-1:0] Req,
    input  logic [n-1:0]       A,
    input  logic [n-1:0]       B,
    input  logic [n-1:0]       C,
    input  logic [n-1:0]       D,
    input  logic               Ready,
    output logic [REQ_NUM-1:0] Gnt,
    output logic [1:0]         S,
    output logic [n-1:0]       Y,
    output logic               Valid
);

    localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

    state_e             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [REQ_NUM-1:0] gnt_q, gnt_d;
    logic [1:0]         s_q, s_d;

    logic  owner_req;
    logic  xfer;
    logic  release_now;
    pick_t idle_pick;
    pick_t rel_pick;

    assign owner_req   = Req[s_q];
    assign Valid       = (state_q == GRANT) && owner_req;
    assign xfer        = Valid && Ready;
    assign release_now = (state_q == GRANT) &&
                         (!owner_req || (xfer && cnt_q == CNT_LAST));

    // Re-arbitration on release starts just past the outgoing owner.
    assign idle_pick = rr_pick(Req, ptr_q);
    assign rel_pick  = rr_pick(Req, s_q + 2'd1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        s_d     = s_q;
        unique case (state_q)
            IDLE: begin
                if (idle_pick.found) begin
                    state_d = GRANT;
                    gnt_d   = onehot(idle_pick.idx);
                    s_d     = idle_pick.idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d = s_q + 2'd1;
                    cnt_d = '0;
                    if (rel_pick.found) begin
                        gnt_d = onehot(rel_pick.idx);
                        s_d   = rel_pick.idx;
                    end else begin
                        // S keeps pointing at the old owner while idle.
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= SEL_A;
            cnt_q   <= '0;
            gnt_q   <= '0;
            s_q     <= SEL_A;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
        end
    end

    assign Gnt = gnt_q;
    assign S   = s_q;

    Mux_4x1_nbit #(.n(n)) u_mux (
        .A (A),
        .B (B),
        .C (C),
        .D (D),
        .S (s_q),
        .Y (Y)
    );

endmodule
